// File: rtl/pc_next_unit_if.sv
// Fetch-address interface between execute-stage branch resolution and the
// PC stage. The master drives redirect controls; the slave (the PC stage)
// returns the fetch address and status.
interface pc_next_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            stall;
    logic            branch;
    logic            jalr;
    logic [XLEN-1:0] immd;
    logic [XLEN-1:0] rs1;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic            fetch_valid;
    logic            misalign;

    modport master (
        output stall,
        output branch,
        output jalr,
        output immd,
        output rs1,
        output trap,
        output trap_vector,
        input  pc,
        input  pc_plus,
        input  fetch_valid,
        input  misalign
    );

    modport slave (
        input  stall,
        input  branch,
        input  jalr,
        input  immd,
        input  rs1,
        input  trap,
        input  trap_vector,
        output pc,
        output pc_plus,
        output fetch_valid,
        output misalign
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the PC and selects the next fetch address.
// Priority: trap > stall > jalr > branch > sequential. A misaligned taken
// target parks the unit in HALT until a trap redirect arrives.
module pc_next_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic          clk,
    input  logic          reset,
    pc_next_unit_if.slave bus
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [XLEN-1:0] INCR     = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
    localparam logic [XLEN-1:0] BIT0     = XLEN'(1);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            misalign_q;
    logic            misalign_d;

    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] tgt_jalr;
    logic [XLEN-1:0] tgt_branch;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] trap_tgt;
    logic            take;
    logic            tgt_bad;

    // Candidate addresses and target alignment check
    always_comb begin
        pc_plus    = pc_q + INCR;
        jalr_sum   = bus.rs1 + bus.immd;
        tgt_jalr   = jalr_sum & ~BIT0;
        tgt_branch = pc_q + bus.immd;
        take       = bus.jalr | bus.branch;
        tgt        = bus.jalr ? tgt_jalr : tgt_branch;
        tgt_bad    = take && ((tgt & LOW_MASK) != '0);
        trap_tgt   = bus.trap_vector & ~LOW_MASK;
    end

    // Next-state and next-PC selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (bus.trap) begin
                    pc_d = trap_tgt;
                end
            end
            ST_RUN: begin
                if (bus.trap) begin
                    pc_d = trap_tgt;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (take) begin
                    if (tgt_bad) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d = tgt;
                    end
                end else begin
                    pc_d = pc_plus;
                end
            end
            ST_HALT: begin
                if (bus.trap) begin
                    pc_d    = trap_tgt;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC and misalign pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus     = pc_plus;
    assign bus.fetch_valid = (state_q == ST_RUN);
    assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed scenarios then random traffic,
// checked against a behavioural model of the next-PC rules.
module tb_pc_next_unit;

    localparam logic [63:0] RV    = 64'h1000;
    localparam logic [63:0] IB    = 64'd4;
    localparam logic [63:0] ALIGN = 64'd4;

    typedef enum {M_BOOT, M_RUN, M_HALT} mmode_t;
    typedef struct {
        logic [63:0] pc;
        logic        fv;
        logic        mis;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    exp_t sbq[$];

    logic [63:0] m_pc;
    mmode_t      m_mode;
    logic        m_mis;

    pc_next_unit_if #(.XLEN(64)) bus ();

    pc_next_unit #(
        .XLEN(64),
        .RESET_VECTOR(RV),
        .INSTR_BYTES(4),
        .ALIGN_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pc", bus.pc, e.pc);
                chk("pc_plus", bus.pc_plus, e.pc + IB);
                chk("fetch_valid", 64'(bus.fetch_valid), 64'(e.fv));
                chk("misalign", 64'(bus.misalign), 64'(e.mis));
            end
        end
    end

    function automatic logic [63:0] align_down(input logic [63:0] a, input logic [63:0] m);
        return a - (a % m);
    endfunction

    // One clock: record expected outputs for this cycle, drive inputs,
    // advance the model across the coming edge.
    task automatic step(input logic st, input logic br, input logic jr,
                        input logic [63:0] im, input logic [63:0] r1,
                        input logic tr, input logic [63:0] tv);
        exp_t        e;
        logic [63:0] t;
        e.pc  = m_pc;
        e.fv  = (m_mode == M_RUN);
        e.mis = m_mis;
        sbq.push_back(e);

        bus.stall       = st;
        bus.branch      = br;
        bus.jalr        = jr;
        bus.immd        = im;
        bus.rs1         = r1;
        bus.trap        = tr;
        bus.trap_vector = tv;

        m_mis = 1'b0;
        case (m_mode)
            M_BOOT: begin
                if (tr) m_pc = align_down(tv, ALIGN);
                m_mode = M_RUN;
            end
            M_RUN: begin
                if (tr) begin
                    m_pc = align_down(tv, ALIGN);
                end else if (st) begin
                    // hold; redirect dropped
                end else if (jr || br) begin
                    t = jr ? align_down(r1 + im, 64'd2) : m_pc + im;
                    if ((t % ALIGN) != 0) begin
                        m_mis  = 1'b1;
                        m_mode = M_HALT;
                    end else begin
                        m_pc = t;
                    end
                end else begin
                    m_pc = m_pc + IB;
                end
            end
            default: begin
                if (tr) begin
                    m_pc   = align_down(tv, ALIGN);
                    m_mode = M_RUN;
                end
            end
        endcase

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_trap(input logic [63:0] tv);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, tv);
    endtask

    task automatic clear_inputs();
        bus.stall       = 1'b0;
        bus.branch      = 1'b0;
        bus.jalr        = 1'b0;
        bus.immd        = '0;
        bus.rs1         = '0;
        bus.trap        = 1'b0;
        bus.trap_vector = '0;
    endtask

    initial begin
        int          k;
        logic        st, br, jr, tr;
        logic [63:0] im, r1, tv;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        clear_inputs();
        m_pc   = RV;
        m_mode = M_BOOT;
        m_mis  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", bus.pc, RV);
        chk("reset_fv", 64'(bus.fetch_valid), 64'd0);
        reset = 1'b0;

        // boot then sequential fetch
        repeat (4) idle();

        // branch backwards, then branch dropped by stall
        do_trap(64'h2000);
        step(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0, 1'b0, '0);
        do_trap(64'h2000);
        step(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0, 1'b0, '0);
        idle();

        // jalr clears bit 0; jalr beats branch
        do_trap(64'h3000);
        step(1'b0, 1'b0, 1'b1, 64'd4, 64'h3001, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 64'd0, 64'h5000, 1'b0, '0);
        idle();

        // misaligned branch, HALT ignores controls, trap exits
        do_trap(64'h4000);
        step(1'b0, 1'b1, 1'b0, 64'd2, '0, 1'b0, '0);
        idle();
        step(1'b0, 1'b1, 1'b0, 64'd8, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 64'd8, 64'h100, 1'b0, '0);
        do_trap(64'h8003);
        idle();

        // wrap-around
        do_trap(64'hFFFF_FFFF_FFFF_FFFC);
        idle();
        step(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b0, '0);
        idle();

        // asynchronous reset while halted with misalign high
        step(1'b0, 1'b0, 1'b1, 64'd2, 64'h7000, 1'b0, '0);
        chk("pre_reset_misalign", 64'(bus.misalign), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_pc", bus.pc, RV);
        chk("async_reset_misalign", 64'(bus.misalign), 64'd0);
        chk("async_reset_fv", 64'(bus.fetch_valid), 64'd0);
        clear_inputs();
        m_pc   = RV;
        m_mode = M_BOOT;
        m_mis  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // trap honoured during BOOT
        do_trap(64'h9001);
        idle();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 3) == 0);
            jr = ($urandom_range(0, 6) == 0);
            tr = ($urandom_range(0, 15) == 0);
            k  = $urandom_range(0, 511);
            im = 64'(k - 256) << 2;
            if ($urandom_range(0, 9) == 0) im = im + 64'($urandom_range(1, 3));
            r1 = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) r1 = r1 & ~64'h3;
            tv = {$urandom, $urandom};
            step(st, br, jr, im, r1, tr, tv);
        end

        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
